// File: rtl/spi_reg_ctrl_pkg.sv
// Shared types and constants for the SPI register controller.
// Frame FSM states and command-byte layout.
package spi_reg_ctrl_pkg;

  localparam int unsigned CMD_RD_BIT = 7;
  localparam int unsigned DATA_W = 8;
  localparam logic [7:0] DEFAULT_STATUS = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WRITE,
    RD_ISSUE,
    RD_LATCH,
    READ
  } spi_ctrl_state_t;

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Simple register bus between the SPI frame controller and a register file.
// Read data is expected one clock after the read strobe.
interface spi_reg_ctrl_if
  import spi_reg_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 7
);

  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [DATA_W-1:0] reg_rdata;

  modport master (
    output reg_addr,
    output reg_wdata,
    output reg_we,
    output reg_re,
    input  reg_rdata
  );

  modport slave (
    input  reg_addr,
    input  reg_wdata,
    input  reg_we,
    input  reg_re,
    output reg_rdata
  );

endinterface

// File: rtl/spi_reg_ctrl.sv
// Frame-level controller behind an SPI slave byte engine.
// Decodes command bytes and sequences register reads/writes.
module spi_reg_ctrl
  import spi_reg_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = 7,
  parameter logic [7:0]  STATUS_BYTE = DEFAULT_STATUS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ss,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_valid,
  output logic [7:0]            tx_byte,
  spi_reg_ctrl_if.master        bus,
  output logic                  frame_done
);

  spi_ctrl_state_t   state_q;
  spi_ctrl_state_t   state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              ss_q;
  logic              cmd_rd;

  assign cmd_rd = rx_byte[CMD_RD_BIT];

  // Next-state decode; ss high always returns to IDLE.
  always_comb begin
    state_d = state_q;
    if (ss) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:     if (ss_q) state_d = CMD;
        CMD:      if (rx_valid) state_d = cmd_rd ? RD_ISSUE : WRITE;
        WRITE:    state_d = WRITE;
        RD_ISSUE: state_d = RD_LATCH;
        RD_LATCH: state_d = READ;
        READ:     if (rx_valid) state_d = RD_ISSUE;
        default:  state_d = IDLE;
      endcase
    end
  end

  // Address counter: loaded by the command, stepped per access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else if (!ss) begin
      unique case (state_q)
        CMD:      if (rx_valid) addr_q <= rx_byte[ADDR_W-1:0];
        WRITE:    if (rx_valid) addr_q <= addr_q + ADDR_W'(1);
        RD_LATCH: addr_q <= addr_q + ADDR_W'(1);
        default:  addr_q <= addr_q;
      endcase
    end
  end

  // State register and registered bus/tx/frame outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ss_q          <= 1'b0;
      tx_byte       <= STATUS_BYTE;
      bus.reg_addr  <= '0;
      bus.reg_wdata <= '0;
      bus.reg_we    <= 1'b0;
      bus.reg_re    <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ss_q       <= ss;
      bus.reg_we <= 1'b0;
      bus.reg_re <= 1'b0;
      frame_done <= 1'b0;
      if (ss) begin
        if (state_q != IDLE) begin
          tx_byte    <= STATUS_BYTE;
          frame_done <= (state_q != CMD);
        end
      end else begin
        unique case (state_q)
          CMD: begin
            if (rx_valid && cmd_rd) begin
              bus.reg_re   <= 1'b1;
              bus.reg_addr <= rx_byte[ADDR_W-1:0];
            end
          end
          WRITE: begin
            if (rx_valid) begin
              bus.reg_we    <= 1'b1;
              bus.reg_addr  <= addr_q;
              bus.reg_wdata <= rx_byte;
            end
          end
          RD_LATCH: tx_byte <= bus.reg_rdata;
          READ: begin
            if (rx_valid) begin
              bus.reg_re   <= 1'b1;
              bus.reg_addr <= addr_q;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl.
// Directed table, hand sequences and random frames vs a frame model.
module tb_spi_reg_ctrl;
  import spi_reg_ctrl_pkg::*;

  localparam int AW = 7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ss = 1'b1;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_byte;
  logic       frame_done;

  spi_reg_ctrl_if #(.ADDR_W(AW)) bus ();

  spi_reg_ctrl #(
    .ADDR_W(AW),
    .STATUS_BYTE(8'hA5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ss(ss),
    .rx_byte(rx_byte),
    .rx_valid(rx_valid),
    .tx_byte(tx_byte),
    .bus(bus),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] dflt(input int i);
    return 8'(i * 37 + 11);
  endfunction

  // register file seen by the DUT
  logic [7:0] env_mem [128];
  bit env_init = 1'b0;
  always @(posedge clk) begin
    if (!env_init) begin
      for (int i = 0; i < 128; i++) env_mem[i] <= dflt(i);
      env_init <= 1'b1;
    end else begin
      if (bus.reg_we) env_mem[bus.reg_addr] <= bus.reg_wdata;
      if (bus.reg_re) bus.reg_rdata <= env_mem[bus.reg_addr];
    end
  end

  // bus monitor
  typedef struct packed {
    logic [6:0] a;
    logic [7:0] d;
  } wr_t;
  wr_t act_wr[$];
  int  re_cnt = 0;
  int  fd_cnt = 0;
  always @(negedge clk) begin
    if (bus.reg_we) act_wr.push_back({bus.reg_addr, bus.reg_wdata});
    if (bus.reg_re) re_cnt++;
    if (frame_done) fd_cnt++;
  end

  // reference memory contents
  logic [7:0] ref_mem [128];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // results of the last frame
  logic [7:0] tx_seen [8];
  int         f_we, f_re, f_fd;
  logic [6:0] f_wa;
  logic [7:0] f_wd;

  task automatic run_frame(input logic [7:0] b [8], input int n,
                           input bit abort);
    int         wr0, re0, fd0, eff;
    wr_t        exp_wr[$];
    logic [6:0] a, idx;
    logic [7:0] exp_tx;
    bit         rd;
    wr0 = act_wr.size();
    re0 = re_cnt;
    fd0 = fd_cnt;
    @(negedge clk) ss = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < n; k++) begin
      tx_seen[k] = tx_byte;
      rx_byte = b[k];
      rx_valid = 1'b1;
      if (abort && k == n - 1) ss = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      repeat (5) @(negedge clk);
    end
    ss = 1'b1;
    repeat (4) @(negedge clk);
    f_we = act_wr.size() - wr0;
    f_re = re_cnt - re0;
    f_fd = fd_cnt - fd0;
    f_wa = '0;
    f_wd = '0;
    if (f_we > 0) begin
      f_wa = act_wr[act_wr.size() - 1].a;
      f_wd = act_wr[act_wr.size() - 1].d;
    end
    // model: bytes that landed before ss rose
    eff = abort ? n - 1 : n;
    a = b[0][6:0];
    rd = b[0][7];
    if (eff > 0 && !rd)
      for (int k = 1; k < eff; k++) begin
        idx = a + 7'(k - 1);
        exp_wr.push_back({idx, b[k]});
      end
    chk("frame_done_cnt", f_fd, (eff > 0) ? 1 : 0);
    chk("reg_re_cnt", f_re, (eff > 0 && rd) ? eff : 0);
    chk("reg_we_cnt", f_we, exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < f_we; i++)
      chk("write_addr_data", act_wr[wr0 + i], exp_wr[i]);
    for (int k = 0; k < n; k++) begin
      idx = a + 7'(k - 1);
      exp_tx = (k > 0 && rd) ? ref_mem[idx] : 8'hA5;
      chk("tx_during_byte", tx_seen[k], exp_tx);
    end
    foreach (exp_wr[i]) ref_mem[exp_wr[i].a] = exp_wr[i].d;
    chk("tx_after_frame", tx_byte, 8'hA5);
  endtask

  typedef struct {
    logic [7:0] b0, b1, b2;
    int         n;
    bit         ab;
    int         we, re, fd;
    logic [6:0] wa;
    logic [7:0] wd, tx;
  } vec_t;

  vec_t       vt [7];
  logic [7:0] fb [8];
  int         wr0, re0;

  initial begin
    for (int i = 0; i < 128; i++) ref_mem[i] = dflt(i);
    for (int i = 0; i < 8; i++) fb[i] = 8'h00;

    vt[0] = '{8'h05, 8'h11, 8'h22, 3, 0, 2, 0, 1, 7'h06, 8'h22, 8'hA5};
    vt[1] = '{8'h85, 8'h00, 8'h00, 3, 1, 0, 2, 1, 7'h00, 8'h00, 8'h22};
    vt[2] = '{8'h7F, 8'h33, 8'h44, 3, 0, 2, 0, 1, 7'h00, 8'h44, 8'hA5};
    vt[3] = '{8'h10, 8'h55, 8'h66, 3, 1, 1, 0, 1, 7'h10, 8'h55, 8'hA5};
    vt[4] = '{8'h85, 8'h00, 8'h00, 1, 0, 0, 1, 1, 7'h00, 8'h00, 8'hA5};
    vt[5] = '{8'h85, 8'h00, 8'h00, 1, 1, 0, 0, 0, 7'h00, 8'h00, 8'hA5};
    vt[6] = '{8'hFF, 8'h00, 8'h00, 3, 0, 0, 3, 1, 7'h00, 8'h00, 8'h44};

    repeat (3) @(negedge clk);
    chk("rst_tx", tx_byte, 8'hA5);
    chk("rst_we", bus.reg_we, 0);
    chk("rst_re", bus.reg_re, 0);
    chk("rst_addr", bus.reg_addr, 0);
    chk("rst_wdata", bus.reg_wdata, 0);
    chk("rst_fd", frame_done, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      fb[0] = vt[i].b0;
      fb[1] = vt[i].b1;
      fb[2] = vt[i].b2;
      run_frame(fb, vt[i].n, vt[i].ab);
      chk("vec_we", f_we, vt[i].we);
      chk("vec_re", f_re, vt[i].re);
      chk("vec_fd", f_fd, vt[i].fd);
      chk("vec_tx_last", tx_seen[vt[i].n - 1], vt[i].tx);
      if (vt[i].we > 0) begin
        chk("vec_wa", f_wa, vt[i].wa);
        chk("vec_wd", f_wd, vt[i].wd);
      end
    end

    // read latency: tx_byte moves on the 3rd clock after rx_valid
    @(negedge clk) ss = 1'b0;
    repeat (3) @(negedge clk);
    rx_byte = 8'h85;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("lat_re_c1", bus.reg_re, 1);
    chk("lat_addr_c1", bus.reg_addr, 7'h05);
    chk("lat_tx_c1", tx_byte, 8'hA5);
    @(negedge clk);
    chk("lat_re_c2", bus.reg_re, 0);
    chk("lat_tx_c2", tx_byte, 8'hA5);
    @(negedge clk);
    chk("lat_tx_c3", tx_byte, ref_mem[5]);
    ss = 1'b1;
    repeat (4) @(negedge clk);
    chk("lat_tx_idle", tx_byte, 8'hA5);

    // async reset in the middle of a read frame
    ss = 1'b0;
    repeat (3) @(negedge clk);
    rx_byte = 8'h85;
    rx_valid = 1'b1;
    @(negedge clk) rx_valid = 1'b0;
    repeat (5) @(negedge clk);
    rx_byte = 8'h00;
    rx_valid = 1'b1;
    @(negedge clk) rx_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_tx", tx_byte, ref_mem[6]);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", tx_byte, 8'hA5);
    chk("mid_rst_addr", bus.reg_addr, 0);
    chk("mid_rst_wdata", bus.reg_wdata, 0);
    chk("mid_rst_we", bus.reg_we, 0);
    chk("mid_rst_re", bus.reg_re, 0);
    chk("mid_rst_fd", frame_done, 0);
    @(negedge clk) rst_n = 1'b1;
    // ss still low: no new frame without a 1->0 edge
    wr0 = act_wr.size();
    re0 = re_cnt;
    repeat (3) @(negedge clk);
    rx_byte = 8'h03;
    rx_valid = 1'b1;
    @(negedge clk) rx_valid = 1'b0;
    repeat (5) @(negedge clk);
    rx_byte = 8'h77;
    rx_valid = 1'b1;
    @(negedge clk) rx_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_rst_no_we", act_wr.size() - wr0, 0);
    chk("post_rst_no_re", re_cnt - re0, 0);
    ss = 1'b1;
    repeat (4) @(negedge clk);
    fb[0] = 8'h03;
    fb[1] = 8'h77;
    run_frame(fb, 2, 1'b0);
    chk("post_rst_frame_we", f_we, 1);

    // random frames against the model
    for (int f = 0; f < 24; f++) begin
      int n;
      bit ab;
      n = $urandom_range(1, 6);
      for (int k = 0; k < 8; k++) fb[k] = 8'($urandom);
      ab = ($urandom_range(0, 3) == 0);
      run_frame(fb, n, ab);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
